// File: rtl/i2c_pkg.sv
// Shared types for the I2C sequencers: engine command opcodes and sequencer state encoding.
package i2c_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_STOP  = 2'd2
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_DATA  = 4'd3,
        S_STOP  = 4'd4,
        S_RESP  = 4'd5
    } seq_state_t;

    localparam logic I2C_WR_BIT = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Shares one byte-level I2C master engine between NUM_REQ requesters; each request is a
// single-byte write (START, addr+W, data, STOP) with round-robin grant and a per-command watchdog.
//
// state | meaning
// IDLE  | waiting for a request; grants in the cycle any req_valid is seen
// START | OP_START issued / waiting for cmd_done
// ADDR  | OP_WRITE {addr,W} issued / waiting for cmd_done
// DATA  | OP_WRITE data issued / waiting for cmd_done
// STOP  | OP_STOP issued / waiting for cmd_done
// RESP  | one-cycle response pulse to the granted requester
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_nack,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 cmd_valid,
    output logic [1:0]           cmd_op,
    output logic [7:0]           cmd_byte,
    input  logic                 cmd_ready,
    input  logic                 cmd_done,
    input  logic                 cmd_ack,
    output logic [3:0]           dbg_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT_CYC - 1);
    localparam logic [WW-1:0] WDOG_TRIP = WW'(TIMEOUT_CYC - 2);

    seq_state_t         state, state_d;
    logic [IW-1:0]      rr_ptr, rr_ptr_d, gnt_idx, gnt_idx_d, arb_idx;
    logic [NUM_REQ-1:0] arb_grant, req_ready_d, rsp_valid_d;
    logic [6:0]         addr_q, addr_d, sel_addr;
    logic [7:0]         data_q, data_d, sel_data;
    logic               nack_q, nack_d, err_q, err_d;
    logic [WW-1:0]      wdog, wdog_d;
    logic               cmd_valid_d, issued, issued_d;
    logic               rsp_nack_d, rsp_err_d, busy_d;
    logic               in_cmd, accept, done_ok, trip, entry;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[7*i +: 7];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign in_cmd  = (state == S_START) || (state == S_ADDR) || (state == S_DATA) || (state == S_STOP);
    assign accept  = cmd_valid && cmd_ready;
    // cmd_done only counts once the current command has actually been handed to the engine
    assign done_ok = in_cmd && issued && cmd_done;
    // wdog reaches TIMEOUT_CYC-1 on the edge that leaves the state
    assign trip    = in_cmd && (wdog >= WDOG_TRIP);

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_idx_d   = gnt_idx;
        addr_d      = addr_q;
        data_d      = data_q;
        nack_d      = nack_q;
        err_d       = err_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_nack_d  = 1'b0;
        rsp_err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d     = S_START;
                    req_ready_d = arb_grant;
                    gnt_idx_d   = arb_idx;
                    addr_d      = sel_addr;
                    data_d      = sel_data;
                    nack_d      = 1'b0;
                    err_d       = 1'b0;
                    rr_ptr_d    = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IW'(1);
                end
            end
            S_START: begin
                if (done_ok) begin
                    state_d = S_ADDR;
                end else if (trip) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_ADDR: begin
                if (done_ok) begin
                    if (cmd_ack) begin
                        state_d = S_DATA;
                    end else begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end
                end else if (trip) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_DATA: begin
                if (done_ok) begin
                    if (!cmd_ack) nack_d = 1'b1;
                    state_d = S_STOP;
                end else if (trip) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (done_ok) begin
                    state_d = S_RESP;
                end else if (trip) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        entry = (state_d != state);

        cmd_valid_d = cmd_valid;
        issued_d    = issued;
        if (accept) begin
            cmd_valid_d = 1'b0;
            issued_d    = 1'b1;
        end
        if (entry) begin
            cmd_valid_d = (state_d == S_START) || (state_d == S_ADDR) ||
                          (state_d == S_DATA)  || (state_d == S_STOP);
            issued_d    = 1'b0;
        end

        wdog_d = wdog;
        if (entry) begin
            wdog_d = '0;
        end else if (in_cmd && wdog != WDOG_MAX) begin
            wdog_d = wdog + WW'(1);
        end

        if (entry && state_d == S_RESP) begin
            rsp_valid_d[gnt_idx] = 1'b1;
            rsp_nack_d           = nack_d;
            rsp_err_d            = err_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        cmd_op   = OP_START;
        cmd_byte = 8'h00;
        case (state)
            S_ADDR: begin
                cmd_op   = OP_WRITE;
                cmd_byte = {addr_q, I2C_WR_BIT};
            end
            S_DATA: begin
                cmd_op   = OP_WRITE;
                cmd_byte = data_q;
            end
            S_STOP:  cmd_op = OP_STOP;
            default: cmd_op = OP_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            wdog      <= '0;
            cmd_valid <= 1'b0;
            issued    <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_nack  <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gnt_idx   <= gnt_idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            nack_q    <= nack_d;
            err_q     <= err_d;
            wdog      <= wdog_d;
            cmd_valid <= cmd_valid_d;
            issued    <= issued_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_nack  <= rsp_nack_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench for i2c_write_sequencer: a behavioural engine model plus a transaction-level
// reference that predicts grants, command streams and responses from the request/ack pattern.
`timescale 1ns/1ps
module tb_i2c_write_sequencer;
    import i2c_pkg::*;

    localparam int NR  = 2;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [7*NR-1:0] req_addr;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ready, rsp_valid;
    logic            rsp_nack, rsp_err, busy, cmd_valid;
    logic [1:0]      cmd_op;
    logic [7:0]      cmd_byte;
    logic            cmd_ready, cmd_done, cmd_ack;
    logic [3:0]      dbg_state;

    always #5 clk = ~clk;

    i2c_write_sequencer #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_err(rsp_err),
        .busy(busy), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_byte(cmd_byte),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_ack(cmd_ack), .dbg_state(dbg_state)
    );

    typedef struct { logic [1:0] op; logic [7:0] b; } cmd_t;
    typedef struct { int idx; int kind; int ref_cyc; } gnt_t;
    typedef struct { logic [NR-1:0] vec; logic nack; logic err; } rsp_t;

    cmd_t exp_cmd[$];
    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    bit   ack_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, rsp_cnt = 0, last_rsp_cyc = -100, model_ptr = 0;
    bit drop_data = 0, stall_stop = 0;

    logic [6:0] t_addr[NR];
    logic [7:0] t_data[NR];
    bit         t_aack[NR], t_dack[NR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic [1:0] op, input logic [7:0] b);
        cmd_t c;
        c.op = op;
        c.b  = b;
        return c;
    endfunction

    // Engine model: ready after 0-3 cycles, done 5-9 cycles after acceptance.
    initial begin
        int  rdy_cnt, done_cnt, wr_idx;
        bit  armed, eng_busy, cur_ack, cur_drop;
        cmd_ready = 0; cmd_done = 0; cmd_ack = 0;
        armed = 0; eng_busy = 0; rdy_cnt = 0; done_cnt = 0; wr_idx = 0; cur_ack = 1; cur_drop = 0;
        forever begin
            @(negedge clk);
            #1;
            cmd_done = 0;
            cmd_ack  = 0;
            if (rst) begin
                cmd_ready = 0; armed = 0; eng_busy = 0;
            end else if (cmd_ready) begin
                cmd_ready = 0;
                eng_busy  = 1;
            end else if (eng_busy) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    eng_busy = 0;
                    if (!cur_drop) begin
                        cmd_done = 1;
                        cmd_ack  = cur_ack;
                    end
                end
            end else if (cmd_valid) begin
                if (!(stall_stop && cmd_op == OP_STOP)) begin
                    if (!armed) begin
                        armed   = 1;
                        rdy_cnt = $urandom_range(3, 0);
                    end
                    if (rdy_cnt == 0) begin
                        cmd_ready = 1;
                        armed     = 0;
                        done_cnt  = $urandom_range(9, 5);
                        cur_ack   = 1;
                        cur_drop  = 0;
                        if (cmd_op == OP_START) wr_idx = 0;
                        if (cmd_op == OP_WRITE) begin
                            if (ack_q.size() > 0) cur_ack = ack_q.pop_front();
                            cur_drop = drop_data && (wr_idx == 1);
                            wr_idx++;
                        end
                    end else begin
                        rdy_cnt--;
                    end
                end
            end else begin
                armed = 0;
            end
        end
    end

    // Monitor: compares every grant, accepted command and response against the scoreboard.
    always @(negedge clk) begin
        gnt_t g;
        cmd_t c;
        rsp_t r;
        #2;
        if (!rst) begin
            if (req_ready != '0) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_grant", 32'(req_ready), 0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("grant_vec", 32'(req_ready), 32'(1) << g.idx);
                    check("grant_busy", 32'(busy), 1);
                    if (g.kind == 0) check("grant_latency", cyc, g.ref_cyc + 1);
                    else             check("b2b_gap", cyc - last_rsp_cyc, 2);
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd_op", 32'(cmd_op), 32'hff);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_op", 32'(cmd_op), 32'(c.op));
                    check("cmd_byte", 32'(cmd_byte), 32'(c.b));
                end
            end
            if (rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(r.vec));
                    check("rsp_nack", 32'(rsp_nack), 32'(r.nack));
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                    check("rsp_busy", 32'(busy), 1);
                end
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
        end
    end

    // mode: 0 normal, 1 engine drops cmd_done of the data byte, 2 engine never readies STOP,
    // 3 reset while in DATA.
    task automatic run_batch(input logic [NR-1:0] mask, input int mode);
        int   order[$];
        int   target, data_cyc, stop_cyc, g;
        rsp_t r;
        bit   abort;
        for (int k = 0; k < NR; k++) begin
            g = (model_ptr + k) % NR;
            if (mask[g]) order.push_back(g);
        end
        for (int i = 0; i < NR; i++) begin
            req_addr[7*i +: 7] = t_addr[i];
            req_data[8*i +: 8] = t_data[i];
        end
        drop_data  = (mode == 1);
        stall_stop = (mode == 2);
        foreach (order[n]) begin
            g = order[n];
            exp_gnt.push_back('{g, (n == 0) ? 0 : 1, cyc});
            exp_cmd.push_back(mk_cmd(OP_START, 8'h00));
            exp_cmd.push_back(mk_cmd(OP_WRITE, {t_addr[g], 1'b0}));
            ack_q.push_back(t_aack[g]);
            if (t_aack[g]) begin
                exp_cmd.push_back(mk_cmd(OP_WRITE, t_data[g]));
                ack_q.push_back(t_dack[g]);
            end
            if (mode != 2) exp_cmd.push_back(mk_cmd(OP_STOP, 8'h00));
            r.vec     = '0;
            r.vec[g]  = 1'b1;
            r.nack    = (mode == 1) ? 1'b0 : (!t_aack[g] || !t_dack[g]);
            r.err     = (mode == 1 || mode == 2);
            exp_rsp.push_back(r);
            model_ptr = (g + 1) % NR;
        end
        target    = rsp_cnt + order.size();
        req_valid = mask;
        data_cyc  = -1;
        stop_cyc  = -1;
        abort     = 0;
        for (int t = 0; t < 150 * NR && rsp_cnt < target && !abort; t++) begin
            @(negedge clk);
            req_valid = req_valid & ~req_ready;
            if (dbg_state == 4'(S_DATA) && data_cyc < 0) data_cyc = cyc;
            if (cmd_valid && cmd_op == OP_STOP && stop_cyc < 0) stop_cyc = cyc;
            if (mode == 3 && dbg_state == 4'(S_DATA)) begin
                rst       = 1;
                req_valid = '0;
                exp_cmd.delete(); exp_gnt.delete(); exp_rsp.delete(); ack_q.delete();
                model_ptr = 0;
                @(negedge clk);
                check("rst_req_ready", 32'(req_ready), 0);
                check("rst_rsp_valid", 32'(rsp_valid), 0);
                check("rst_rsp_nack", 32'(rsp_nack), 0);
                check("rst_rsp_err", 32'(rsp_err), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_cmd_valid", 32'(cmd_valid), 0);
                check("rst_cmd_op", 32'(cmd_op), 0);
                check("rst_cmd_byte", 32'(cmd_byte), 0);
                check("rst_dbg_state", 32'(dbg_state), 0);
                rst   = 0;
                abort = 1;
            end
        end
        if (!abort) begin
            check("batch_completed", rsp_cnt, target);
            if (mode == 1) check("data_to_stop_cycles", stop_cyc - data_cyc, TMO - 1);
            if (mode == 2) begin
                for (int t = 0; t < 3; t++) begin
                    @(negedge clk);
                    check("cmd_valid_after_abort", 32'(cmd_valid), 0);
                    check("busy_after_abort", 32'(busy), 0);
                end
            end
        end
        req_valid  = '0;
        drop_data  = 0;
        stall_stop = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d,
                           input bit aa, input bit da);
        t_addr[i] = a;
        t_data[i] = d;
        t_aack[i] = aa;
        t_dack[i] = da;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1; req_valid = '0; req_addr = '0; req_data = '0;
        repeat (3) @(negedge clk);
        check("init_req_ready", 32'(req_ready), 0);
        check("init_rsp_valid", 32'(rsp_valid), 0);
        check("init_busy", 32'(busy), 0);
        check("init_cmd_valid", 32'(cmd_valid), 0);
        check("init_dbg_state", 32'(dbg_state), 0);
        rst = 0;
        @(negedge clk);

        set_req(0, 7'h55, 8'hAA, 1, 1);
        run_batch(2'b01, 0);

        set_req(0, 7'h10, 8'h01, 1, 1);
        set_req(1, 7'h20, 8'h02, 1, 1);
        run_batch(2'b11, 0);
        run_batch(2'b11, 0);

        set_req(0, 7'h33, 8'h5A, 0, 1);
        run_batch(2'b01, 0);

        set_req(1, 7'h44, 8'hC3, 1, 0);
        run_batch(2'b10, 0);

        set_req(0, 7'h21, 8'h7E, 1, 1);
        run_batch(2'b01, 1);

        set_req(1, 7'h12, 8'h81, 1, 1);
        run_batch(2'b10, 2);

        set_req(0, 7'h66, 8'h99, 1, 1);
        run_batch(2'b01, 3);

        set_req(0, 7'h01, 8'h11, 1, 1);
        set_req(1, 7'h02, 8'h22, 1, 1);
        run_batch(2'b11, 0);
        run_batch(2'b10, 0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 7'($urandom), 8'($urandom), $urandom_range(9, 0) != 0,
                        $urandom_range(9, 0) != 0);
            run_batch(NR'($urandom_range(3, 1)), 0);
        end

        check("leftover_cmd", exp_cmd.size(), 0);
        check("leftover_grant", exp_gnt.size(), 0);
        check("leftover_rsp", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
